// File: rtl/cti_resolve_queue.sv
// Frontend control-transfer queue: allocates CTI IDs in program order, absorbs
// out-of-order resolutions with mispredict detection, and retires in order as update packets.
module cti_resolve_queue #(
  parameter int DEPTH  = 16,
  parameter int ID_W   = 4,
  parameter int PC_W   = 32,
  parameter int TYPE_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              allocValid_i,
  input  logic [PC_W-1:0]   allocPC_i,
  input  logic [TYPE_W-1:0] allocType_i,
  input  logic              allocPredDir_i,
  input  logic [PC_W-1:0]   allocPredNPC_i,
  output logic              allocReady_o,
  output logic [ID_W-1:0]   allocID_o,
  input  logic              exeCtrlValid_i,
  input  logic [ID_W-1:0]   exeCtiID_i,
  input  logic [PC_W-1:0]   exeCtrlPC_i,
  input  logic [TYPE_W-1:0] exeCtrlType_i,
  input  logic [PC_W-1:0]   exeCtrlNPC_i,
  input  logic              exeCtrlDir_i,
  output logic              mispredict_o,
  output logic [ID_W-1:0]   mispredictID_o,
  output logic [PC_W-1:0]   mispredictNPC_o,
  input  logic              commitCti_i,
  output logic              updValid_o,
  output logic [PC_W-1:0]   updPC_o,
  output logic [TYPE_W-1:0] updType_o,
  output logic              updDir_o,
  output logic [PC_W-1:0]   updNPC_o,
  output logic [ID_W:0]     count_o,
  output logic              protoErr_o
);

  localparam logic [ID_W:0] FULL_CNT = (ID_W+1)'(DEPTH);

  logic [DEPTH-1:0]  valid_q, valid_d, resolved_q, resolved_d;
  logic [PC_W-1:0]   pc_q       [DEPTH];
  logic [TYPE_W-1:0] type_q     [DEPTH];
  logic              pred_dir_q [DEPTH];
  logic [PC_W-1:0]   pred_npc_q [DEPTH];
  logic              act_dir_q  [DEPTH];
  logic [PC_W-1:0]   act_npc_q  [DEPTH];

  logic [ID_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [ID_W:0]     count_q, count_d;
  logic              mispredict_q, mispredict_d;
  logic [ID_W-1:0]   mis_id_q, mis_id_d;
  logic [PC_W-1:0]   mis_npc_q, mis_npc_d;
  logic              upd_valid_q, upd_valid_d;
  logic [PC_W-1:0]   upd_pc_q, upd_pc_d;
  logic [TYPE_W-1:0] upd_type_q, upd_type_d;
  logic              upd_dir_q, upd_dir_d;
  logic [PC_W-1:0]   upd_npc_q, upd_npc_d;
  logic              proto_err_q, proto_err_d;

  logic alloc_fire, res_hit, res_mis, commit_ok;
  logic unused_type;

  // The resolved type is not needed: the update packet carries the type captured at rename.
  assign unused_type = ^exeCtrlType_i;

  // A stale wrong-path resolution (dead entry, already resolved, or PC mismatch) is dropped.
  always_comb begin
    alloc_fire = allocValid_i && (count_q != FULL_CNT) && !flush_i;
    res_hit    = exeCtrlValid_i && !flush_i && valid_q[exeCtiID_i] &&
                 !resolved_q[exeCtiID_i] && (pc_q[exeCtiID_i] == exeCtrlPC_i);
    res_mis    = res_hit && ((exeCtrlDir_i != pred_dir_q[exeCtiID_i]) ||
                             (exeCtrlNPC_i != pred_npc_q[exeCtiID_i]));
    commit_ok  = commitCti_i && (count_q != '0) && valid_q[head_q] && resolved_q[head_q];
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    valid_d      = valid_q;
    resolved_d   = resolved_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    mispredict_d = res_mis;
    mis_id_d     = res_mis ? exeCtiID_i : mis_id_q;
    mis_npc_d    = res_mis ? exeCtrlNPC_i : mis_npc_q;
    upd_valid_d  = commit_ok;
    upd_pc_d     = commit_ok ? pc_q[head_q]      : upd_pc_q;
    upd_type_d   = commit_ok ? type_q[head_q]    : upd_type_q;
    upd_dir_d    = commit_ok ? act_dir_q[head_q] : upd_dir_q;
    upd_npc_d    = commit_ok ? act_npc_q[head_q] : upd_npc_q;
    proto_err_d  = proto_err_q | (commitCti_i && !commit_ok);

    if (flush_i) begin
      valid_d    = '0;
      resolved_d = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (res_hit) resolved_d[exeCtiID_i] = 1'b1;
      if (commit_ok) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + 1'b1;
      end
      if (alloc_fire) begin
        valid_d[tail_q]    = 1'b1;
        resolved_d[tail_q] = 1'b0;
        tail_d             = tail_q + 1'b1;
      end
      count_d = count_q + (ID_W+1)'(alloc_fire) - (ID_W+1)'(commit_ok);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q      <= '0;
      resolved_q   <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      mispredict_q <= 1'b0;
      mis_id_q     <= '0;
      mis_npc_q    <= '0;
      upd_valid_q  <= 1'b0;
      upd_pc_q     <= '0;
      upd_type_q   <= '0;
      upd_dir_q    <= 1'b0;
      upd_npc_q    <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      resolved_q   <= resolved_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      mispredict_q <= mispredict_d;
      mis_id_q     <= mis_id_d;
      mis_npc_q    <= mis_npc_d;
      upd_valid_q  <= upd_valid_d;
      upd_pc_q     <= upd_pc_d;
      upd_type_q   <= upd_type_d;
      upd_dir_q    <= upd_dir_d;
      upd_npc_q    <= upd_npc_d;
      proto_err_q  <= proto_err_d;
    end
  end

  // NOTE: payload arrays have no reset; valid_q gates every use, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      pc_q[tail_q]       <= allocPC_i;
      type_q[tail_q]     <= allocType_i;
      pred_dir_q[tail_q] <= allocPredDir_i;
      pred_npc_q[tail_q] <= allocPredNPC_i;
    end
    if (res_hit) begin
      act_dir_q[exeCtiID_i] <= exeCtrlDir_i;
      act_npc_q[exeCtiID_i] <= exeCtrlNPC_i;
    end
  end

  assign allocReady_o    = (count_q != FULL_CNT);
  assign allocID_o       = tail_q;
  assign mispredict_o    = mispredict_q;
  assign mispredictID_o  = mis_id_q;
  assign mispredictNPC_o = mis_npc_q;
  assign updValid_o      = upd_valid_q;
  assign updPC_o         = upd_pc_q;
  assign updType_o       = upd_type_q;
  assign updDir_o        = upd_dir_q;
  assign updNPC_o        = upd_npc_q;
  assign count_o         = count_q;
  assign protoErr_o      = proto_err_q;

endmodule

// File: tb/tb_cti_resolve_queue.sv
// Self-checking bench for cti_resolve_queue: directed scenarios plus random traffic
// compared against an in-order queue model of the CTI window.
module tb_cti_resolve_queue;
  localparam int DEPTH = 16;

  logic        clk = 1'b0, reset = 1'b0;
  logic        flush, av, apdir, rv, rdir, cm;
  logic [31:0] apc, apnpc, rpc, rnpc;
  logic [1:0]  atyp, rtyp;
  logic [3:0]  rid;
  logic        ready, mis, upd_v, upd_dir, perr;
  logic [3:0]  aid, mis_id;
  logic [31:0] mis_npc, upd_pc, upd_npc;
  logic [1:0]  upd_typ;
  logic [4:0]  cnt;

  int n_cmp = 0, n_err = 0;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  typ;
    logic        pdir;
    logic [31:0] pnpc;
    bit          res;
    logic        adir;
    logic [31:0] anpc;
  } ent_t;

  ent_t mq[$];
  int   head_id = 0;
  bit   m_perr  = 0;

  cti_resolve_queue #(.DEPTH(16), .ID_W(4), .PC_W(32), .TYPE_W(2)) dut (
    .clk(clk), .reset(reset), .flush_i(flush),
    .allocValid_i(av), .allocPC_i(apc), .allocType_i(atyp),
    .allocPredDir_i(apdir), .allocPredNPC_i(apnpc),
    .allocReady_o(ready), .allocID_o(aid),
    .exeCtrlValid_i(rv), .exeCtiID_i(rid), .exeCtrlPC_i(rpc), .exeCtrlType_i(rtyp),
    .exeCtrlNPC_i(rnpc), .exeCtrlDir_i(rdir),
    .mispredict_o(mis), .mispredictID_o(mis_id), .mispredictNPC_o(mis_npc),
    .commitCti_i(cm), .updValid_o(upd_v), .updPC_o(upd_pc), .updType_o(upd_typ),
    .updDir_o(upd_dir), .updNPC_o(upd_npc), .count_o(cnt), .protoErr_o(perr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush = 0; av = 0; apc = '0; atyp = '0; apdir = 0; apnpc = '0;
    rv = 0; rid = '0; rpc = '0; rtyp = '0; rnpc = '0; rdir = 0; cm = 0;
  endtask

  // One clock: check combinational state, advance the model, check registered results.
  task automatic cycle();
    int   sz, pos;
    bit   c_ok, e_mis, e_upd;
    ent_t e, hd;
    logic [3:0]  e_mid;
    logic [31:0] e_mnpc;
    #1;
    sz = mq.size();
    check("allocReady", ready, 64'(sz != DEPTH));
    check("allocID", aid, 64'((head_id + sz) % DEPTH));
    check("count_pre", cnt, 64'(sz));
    e_mis = 0; e_upd = 0; e_mid = '0; e_mnpc = '0;
    c_ok = cm && (sz > 0) && mq[0].res;
    if (c_ok) begin
      e_upd = 1;
      hd = mq[0];
    end
    if (cm && !c_ok) m_perr = 1;
    if (rv && !flush) begin
      pos = (int'(rid) - head_id + DEPTH) % DEPTH;
      if (pos < sz && !mq[pos].res && mq[pos].pc == rpc) begin
        mq[pos].res  = 1;
        mq[pos].adir = rdir;
        mq[pos].anpc = rnpc;
        e_mis  = (rdir != mq[pos].pdir) || (rnpc != mq[pos].pnpc);
        e_mid  = rid;
        e_mnpc = rnpc;
      end
    end
    if (flush) begin
      mq.delete();
      head_id = 0;
    end else begin
      if (c_ok) begin
        void'(mq.pop_front());
        head_id = (head_id + 1) % DEPTH;
      end
      if (av && sz != DEPTH) begin
        e = '{pc: apc, typ: atyp, pdir: apdir, pnpc: apnpc, res: 0, adir: 0, anpc: '0};
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    check("mispredict", mis, 64'(e_mis));
    if (e_mis) begin
      check("mispredictID", mis_id, 64'(e_mid));
      check("mispredictNPC", mis_npc, 64'(e_mnpc));
    end
    check("updValid", upd_v, 64'(e_upd));
    if (e_upd) begin
      check("updPC", upd_pc, 64'(hd.pc));
      check("updType", upd_typ, 64'(hd.typ));
      check("updDir", upd_dir, 64'(hd.adir));
      check("updNPC", upd_npc, 64'(hd.anpc));
    end
    check("count_post", cnt, 64'(mq.size()));
    check("protoErr", perr, 64'(m_perr));
  endtask

  task automatic do_reset();
    reset = 0;
    idle();
    @(posedge clk);
    #1;
    reset = 1;
    mq.delete();
    head_id = 0;
    m_perr  = 0;
  endtask

  task automatic alloc1(input logic [31:0] pc, input logic [31:0] npc, input logic dir);
    idle(); av = 1; apc = pc; apnpc = npc; apdir = dir; atyp = pc[5:4];
    cycle(); idle();
  endtask

  task automatic resolve1(input logic [3:0] id, input logic [31:0] pc,
                          input logic [31:0] npc, input logic dir);
    idle(); rv = 1; rid = id; rpc = pc; rnpc = npc; rdir = dir; rtyp = 2'd1;
    cycle(); idle();
  endtask

  task automatic commit1();
    idle(); cm = 1; cycle(); idle();
  endtask

  initial begin
    int          pos;
    logic [31:0] pc;
    idle();
    #2;
    check("rst_count", cnt, 0);
    check("rst_ready", ready, 1);
    check("rst_allocID", aid, 0);
    check("rst_mis", mis, 0);
    check("rst_upd", upd_v, 0);
    check("rst_perr", perr, 0);
    do_reset();

    // In-order allocate / resolve / commit of three CTIs.
    for (int i = 1; i <= 3; i++) alloc1(32'(i * 'h100), 32'(i * 'h100 + 4), 1'b1);
    check("three_count", cnt, 3);
    for (int i = 0; i < 3; i++) resolve1(4'(i), 32'((i + 1) * 'h100), 32'((i + 1) * 'h100 + 4), 1'b1);
    for (int i = 0; i < 3; i++) commit1();
    check("three_empty", cnt, 0);

    // Full queue, blocked allocation alongside a commit, tail wrap.
    do_reset();
    for (int i = 0; i < DEPTH; i++) alloc1(32'('h1000 + i * 16), 32'('h1004 + i * 16), 1'b0);
    check("full_ready", ready, 0);
    check("full_count", cnt, 16);
    resolve1(4'd0, 32'h1000, 32'h1004, 1'b0);
    idle(); av = 1; apc = 32'h7000; apnpc = 32'h7004; cm = 1;
    cycle(); idle();
    check("full_commit_count", cnt, 15);
    check("wrap_allocID", aid, 0);
    alloc1(32'h7000, 32'h7004, 1'b0);
    check("wrap_count", cnt, 16);

    // Mispredict, stale PC drop, commit on an unresolved head.
    do_reset();
    for (int i = 1; i <= 3; i++) alloc1(32'(i * 'h100), 32'(i * 'h100 + 4), 1'b1);
    resolve1(4'd2, 32'h300, 32'h400, 1'b1);
    check("mis_pulse", mis, 1);
    check("mis_id", mis_id, 2);
    check("mis_npc", mis_npc, 32'h400);
    resolve1(4'd1, 32'h999, 32'h204, 1'b1);
    check("stale_nopulse", mis, 0);
    resolve1(4'd0, 32'h100, 32'h104, 1'b1);
    commit1();
    commit1();
    check("perr_set", perr, 1);
    check("perr_noupd", upd_v, 0);
    check("perr_count", cnt, 2);

    // Flush with a legal commit, a mispredicting resolve and an allocation.
    do_reset();
    alloc1(32'h100, 32'h104, 1'b1);
    alloc1(32'h200, 32'h204, 1'b1);
    resolve1(4'd0, 32'h100, 32'h104, 1'b1);
    idle(); flush = 1; cm = 1; av = 1; apc = 32'h300; apnpc = 32'h304;
    rv = 1; rid = 4'd1; rpc = 32'h200; rnpc = 32'h888; rdir = 1'b0;
    cycle(); idle();
    check("flush_upd", upd_v, 1);
    check("flush_nomis", mis, 0);
    cycle();
    check("flush_count", cnt, 0);
    check("flush_allocID", aid, 0);
    check("flush_single_upd", upd_v, 0);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      idle();
      if ($urandom_range(99) < 55) begin
        av = 1; apc = $urandom & 32'hFFFF_FFFC; apdir = 1'($urandom);
        apnpc = $urandom & 32'hFFFF_FFFC; atyp = 2'($urandom);
      end
      if ($urandom_range(99) < 50) begin
        rv = 1; rid = 4'($urandom); rtyp = 2'($urandom);
        pos = (int'(rid) - head_id + DEPTH) % DEPTH;
        rpc = (pos < mq.size() && $urandom_range(3) != 0) ? mq[pos].pc : $urandom;
        if (pos < mq.size() && $urandom_range(1) == 0) begin
          rdir = mq[pos].pdir; rnpc = mq[pos].pnpc;
        end else begin
          rdir = 1'($urandom); rnpc = $urandom;
        end
      end
      if (mq.size() > 0 && mq[0].res) cm = ($urandom_range(99) < 60);
      else cm = ($urandom_range(99) < 3);
      flush = ($urandom_range(99) < 2);
      cycle();
    end

    // Asynchronous reset with live entries and a set error flag.
    do_reset();
    commit1();
    for (int i = 0; i < 6; i++) alloc1(32'('h2000 + i * 16), 32'('h2004 + i * 16), 1'b1);
    resolve1(4'd0, 32'h2000, 32'h5550, 1'b0);
    idle(); cm = 1; rv = 1; rid = 4'd1; pc = 32'h2010; rpc = pc; rnpc = 32'h6660; rdir = 1'b0;
    cycle(); idle();
    check("pre_rst_count", cnt, 5);
    check("pre_rst_perr", perr, 1);
    #2;
    reset = 0;
    #1;
    check("arst_count", cnt, 0);
    check("arst_ready", ready, 1);
    check("arst_allocID", aid, 0);
    check("arst_mis", mis, 0);
    check("arst_mis_id", mis_id, 0);
    check("arst_mis_npc", mis_npc, 0);
    check("arst_upd", upd_v, 0);
    check("arst_upd_pc", upd_pc, 0);
    check("arst_upd_type", upd_typ, 0);
    check("arst_upd_dir", upd_dir, 0);
    check("arst_upd_npc", upd_npc, 0);
    check("arst_perr", perr, 0);
    @(posedge clk);
    #1;
    reset = 1;
    mq.delete(); head_id = 0; m_perr = 0;
    cycle();
    check("post_rst_nopulse", mis | upd_v, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
